// File: rtl/spi_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the SPI request arbiter: controller state encoding,
// the SPI address enable bit, the default response timeout and a helper that
// builds the 5-bit SPI address from a 2-bit slave index.
// -----------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic ADDR_EN         = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 100;

    // SPI address layout: {enable, 2'b00, slave[1:0]}
    function automatic logic [4:0] make_spi_addr(input logic [1:0] slave);
        return {ADDR_EN, 2'b00, slave};
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_req_arbiter_if
// Bundles the requester-side handshake and the SPI-master-side handshake of
// the arbiter.
//   slave  modport : the arbiter itself (consumes requests, drives grants,
//                    responses and the SPI launch signals)
//   master modport : the environment (requesters plus the SPI master)
// Signals:
//   req/req_slave/req_wdata   per-requester level request, slave index, word
//   gnt/rsp_valid/rsp_err     one-hot grant, one-hot completion, timeout flag
//   rsp_rdata                 word returned from the slave
//   spi_start/spi_addr/spi_din    launch to the SPI top
//   spi_dout/spi_done/spi_ready/spi_busy  status back from the SPI top
// -----------------------------------------------------------------------------
interface spi_req_arbiter_if #(
    parameter int REG_WIDTH = 32,
    parameter int N_REQ     = 4
);

    logic [N_REQ-1:0]           req;
    logic [2*N_REQ-1:0]         req_slave;
    logic [N_REQ*REG_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           rsp_valid;
    logic                       rsp_err;
    logic [REG_WIDTH-1:0]       rsp_rdata;
    logic                       spi_start;
    logic [4:0]                 spi_addr;
    logic [REG_WIDTH-1:0]       spi_din;
    logic [REG_WIDTH-1:0]       spi_dout;
    logic                       spi_done;
    logic                       spi_ready;
    logic                       spi_busy;

    modport slave (
        input  req, req_slave, req_wdata,
        output gnt, rsp_valid, rsp_err, rsp_rdata,
        output spi_start, spi_addr, spi_din,
        input  spi_dout, spi_done, spi_ready, spi_busy
    );

    modport master (
        output req, req_slave, req_wdata,
        input  gnt, rsp_valid, rsp_err, rsp_rdata,
        input  spi_start, spi_addr, spi_din,
        output spi_dout, spi_done, spi_ready, spi_busy
    );

endinterface

// File: rtl/spi_req_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Starting at i_ptr and wrapping,
// the first asserted request wins.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this pick
//   o_gnt   : one-hot winner
//   o_idx   : binary index of the winner
//   o_valid : at least one request was present
// -----------------------------------------------------------------------------
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        // NOTE: every output is given a default before the search loop so no
        // path leaves a value unassigned, which would otherwise infer a latch.
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [PTR_W-1:0] w_pos;
            w_pos = PTR_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// spi_req_arbiter
// Shares one SPI master among N_REQ requesters. A round-robin winner is
// granted, its slave address and word are latched and launched, and the
// SPI completion (or a timeout) is returned to that requester as a one-cycle
// response.
//   clk  : clock, all logic on posedge
//   rst  : asynchronous, active-high reset
//   bus  : spi_req_arbiter_if.slave (requester and SPI master handshakes)
// Timing: gnt -> spi_start is 1 cycle, spi_done -> rsp_valid is 1 cycle,
// a missing spi_done gives rsp_valid/rsp_err TIMEOUT+1 cycles after spi_start.
// -----------------------------------------------------------------------------
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    spi_req_arbiter_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e           r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic [N_REQ-1:0]     r_win_oh;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_rsp_valid;
    logic                 r_rsp_err;
    logic [REG_WIDTH-1:0] r_rsp_rdata;
    logic                 r_spi_start;
    logic [4:0]           r_spi_addr;
    logic [REG_WIDTH-1:0] r_spi_din;

    logic [N_REQ-1:0]     w_pick_gnt;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_launch_ok;
    logic [1:0]           w_slave;
    logic [REG_WIDTH-1:0] w_wdata;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_launch_ok = w_pick_valid && bus.spi_ready && !bus.spi_busy;
    assign w_slave     = bus.req_slave[2*int'(w_pick_idx) +: 2];
    assign w_wdata     = bus.req_wdata[int'(w_pick_idx)*REG_WIDTH +: REG_WIDTH];

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_win_oh    <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_spi_start <= 1'b0;
            r_spi_addr  <= '0;
            r_spi_din   <= '0;
        end else begin
            // Pulse outputs default low; the state arms them for one cycle.
            r_gnt       <= '0;
            r_spi_start <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch_ok) begin
                        r_gnt      <= w_pick_gnt;
                        r_win      <= w_pick_idx;
                        r_win_oh   <= w_pick_gnt;
                        r_spi_addr <= make_spi_addr(w_slave);
                        r_spi_din  <= w_wdata;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_spi_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // Done wins over timeout when both land in the same cycle.
                    if (bus.spi_done) begin
                        r_rsp_valid <= r_win_oh;
                        r_rsp_rdata <= bus.spi_dout;
                        r_state     <= RESP;
                    end else if (!r_spi_start) begin
                        // The count window opens the cycle after the start
                        // pulse, giving the master TIMEOUT full cycles.
                        if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_rsp_valid <= r_win_oh;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_ptr   <= (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.spi_start = r_spi_start;
    assign bus.spi_addr  = r_spi_addr;
    assign bus.spi_din   = r_spi_din;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_req_arbiter
// Scoreboard bench: the stimulus process pushes the expected grant and
// response for each transfer; a monitor pops and compares whenever the DUT
// shows gnt or rsp_valid. A small SPI master model answers spi_start with
// spi_done after a programmable delay, returning spi_din + 32'h242.
// Requester words: r0 slave2 a8000545, r1 slave1 00001000,
//                  r2 slave3 12345678, r3 slave0 fffffe00.
// -----------------------------------------------------------------------------
module tb_spi_req_arbiter;
    import spi_arb_pkg::*;

    localparam int REG_WIDTH = 32;
    localparam int N_REQ     = 4;
    localparam int TIMEOUT   = 100;

    typedef struct {
        int          idx;
        logic [4:0]  addr;
        logic [31:0] din;
    } exp_gnt_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.REG_WIDTH(REG_WIDTH), .N_REQ(N_REQ)) bus ();

    spi_req_arbiter #(
        .REG_WIDTH (REG_WIDTH),
        .N_REQ     (N_REQ),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_seen = 0;
    int gnt_seen = 0;
    int gnt_cyc   = 0;
    int start_cyc = 0;
    int done_delay = 70;          // 0 means the model never answers
    int stray_req_cnt  = 0;
    int stray_done_cnt = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_din  = '0;
    exp_gnt_t exp_gnt[$];
    exp_rsp_t exp_rsp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int i);
        return N_REQ'(1) << i;
    endfunction

    function automatic void exp_g(input int idx, input logic [4:0] addr, input logic [31:0] din);
        exp_gnt_t e;
        e.idx = idx; e.addr = addr; e.din = din;
        exp_gnt.push_back(e);
    endfunction

    function automatic void exp_r(input int idx, input logic err, input logic [31:0] rdata, input int lat);
        exp_rsp_t e;
        e.idx = idx; e.err = err; e.rdata = rdata; e.lat = lat;
        exp_rsp.push_back(e);
    endfunction

    // Monitor: compare every grant and response against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.spi_start) begin
                    check("gnt_to_start", cyc - gnt_cyc, 1);
                    start_cyc = cyc;
                end
                if (bus.gnt != '0) begin
                    gnt_seen++;
                    gnt_cyc = cyc;
                    if (exp_gnt.size() == 0) begin
                        check("unexpected_gnt", bus.gnt, 0);
                    end else begin
                        exp_gnt_t e;
                        e = exp_gnt.pop_front();
                        check("gnt_onehot", bus.gnt, onehot(e.idx));
                        check("gnt_spi_addr", bus.spi_addr, e.addr);
                        check("gnt_spi_din", bus.spi_din, e.din);
                        last_addr = e.addr;
                        last_din  = e.din;
                    end
                end
                if (bus.rsp_valid != '0) begin
                    rsp_seen++;
                    if (exp_rsp.size() == 0) begin
                        check("unexpected_rsp", bus.rsp_valid, 0);
                    end else begin
                        exp_rsp_t r;
                        r = exp_rsp.pop_front();
                        check("rsp_onehot", bus.rsp_valid, onehot(r.idx));
                        check("rsp_err", bus.rsp_err, r.err);
                        check("rsp_rdata", bus.rsp_rdata, r.rdata);
                        check("rsp_latency", cyc - start_cyc, r.lat);
                        check("hold_spi_addr", bus.spi_addr, last_addr);
                        check("hold_spi_din", bus.spi_din, last_din);
                    end
                end else if (bus.rsp_err) begin
                    check("rsp_err_alone", bus.rsp_err, 0);
                end
            end
        end
    end

    // SPI master model.
    initial begin
        int          countdown;
        bit          pending;
        logic [31:0] pend_dout;
        countdown = 0;
        pending   = 1'b0;
        pend_dout = '0;
        bus.spi_done = 1'b0;
        bus.spi_dout = 32'hdead_beef;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            bus.spi_dout = 32'hdead_beef;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    countdown--;
                    if (countdown == 0) begin
                        bus.spi_done = 1'b1;
                        bus.spi_dout = pend_dout;
                        pending      = 1'b0;
                    end
                end
                if (stray_done_cnt != stray_req_cnt) begin
                    bus.spi_done = 1'b1;
                    stray_done_cnt++;
                end
                if (bus.spi_start && done_delay > 0) begin
                    pending   = 1'b1;
                    countdown = done_delay;
                    pend_dout = bus.spi_din + 32'h0000_0242;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},       bus.gnt, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_err"},   bus.rsp_err, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_spi_start"}, bus.spi_start, 0);
        check({tag, "_spi_addr"},  bus.spi_addr, 0);
        check({tag, "_spi_din"},   bus.spi_din, 0);
    endtask

    task automatic do_reset(input string tag);
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero(tag);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Run until n_rsp more responses arrive; optionally drop each granted req.
    task automatic serve(input int n_rsp, input bit drop, input int budget);
        int target;
        int k;
        target = rsp_seen + n_rsp;
        k = 0;
        while (rsp_seen < target && k < budget) begin
            @(negedge clk);
            if (drop) bus.req = bus.req & ~bus.gnt;
            k++;
        end
        bus.req = '0;
        check("rsp_count", rsp_seen, target);
    endtask

    initial begin
        int prev;
        int k;
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_slave = {2'd0, 2'd3, 2'd1, 2'd2};
        bus.req_wdata = {32'hffff_fe00, 32'h1234_5678, 32'h0000_1000, 32'ha800_0545};
        bus.spi_ready = 1'b1;
        bus.spi_busy  = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single request, done 70 cycles after start.
        done_delay = 70;
        exp_g(0, 5'b10010, 32'ha800_0545);
        exp_r(0, 1'b0, 32'ha800_0787, 71);
        bus.req = 4'b0001;
        serve(1, 1'b1, 400);

        // spi_done while idle must not produce a response.
        prev = rsp_seen;
        stray_req_cnt++;
        repeat (5) @(negedge clk);
        check("stray_done_ignored", rsp_seen, prev);

        // Simultaneous req[0] and req[2] from ptr=0.
        do_reset("rst_sim");
        exp_g(0, 5'b10010, 32'ha800_0545);
        exp_r(0, 1'b0, 32'ha800_0787, 71);
        exp_g(2, 5'b10011, 32'h1234_5678);
        exp_r(2, 1'b0, 32'h1234_58ba, 71);
        bus.req = 4'b0101;
        serve(2, 1'b1, 600);

        // Fairness: all requests held for five transfers.
        do_reset("rst_fair");
        done_delay = 5;
        exp_g(0, 5'b10010, 32'ha800_0545); exp_r(0, 1'b0, 32'ha800_0787, 6);
        exp_g(1, 5'b10001, 32'h0000_1000); exp_r(1, 1'b0, 32'h0000_1242, 6);
        exp_g(2, 5'b10011, 32'h1234_5678); exp_r(2, 1'b0, 32'h1234_58ba, 6);
        exp_g(3, 5'b10000, 32'hffff_fe00); exp_r(3, 1'b0, 32'h0000_0042, 6);
        exp_g(0, 5'b10010, 32'ha800_0545); exp_r(0, 1'b0, 32'ha800_0787, 6);
        bus.req = 4'b1111;
        serve(5, 1'b0, 400);

        // Timeout: no done at all (ptr is now 1).
        done_delay = 0;
        exp_g(1, 5'b10001, 32'h0000_1000);
        exp_r(1, 1'b1, 32'h0000_0000, TIMEOUT + 1);
        bus.req = 4'b0010;
        serve(1, 1'b1, 400);

        // Normal transfer right after a timeout.
        done_delay = 10;
        exp_g(2, 5'b10011, 32'h1234_5678);
        exp_r(2, 1'b0, 32'h1234_58ba, 11);
        bus.req = 4'b0100;
        serve(1, 1'b1, 200);

        // Done exactly on the last counted cycle: still a success.
        done_delay = TIMEOUT;
        exp_g(3, 5'b10000, 32'hffff_fe00);
        exp_r(3, 1'b0, 32'h0000_0042, TIMEOUT + 1);
        bus.req = 4'b1000;
        serve(1, 1'b1, 400);

        // Done one cycle too late: timeout, and the late done is ignored.
        done_delay = TIMEOUT + 1;
        exp_g(0, 5'b10010, 32'ha800_0545);
        exp_r(0, 1'b1, 32'h0000_0000, TIMEOUT + 1);
        bus.req = 4'b0001;
        serve(1, 1'b1, 400);
        prev = rsp_seen;
        repeat (4) @(negedge clk);
        check("late_done_ignored", rsp_seen, prev);

        // Reset 30 cycles into WAIT (ptr is 1, only req[2] asks).
        done_delay = 70;
        exp_g(2, 5'b10011, 32'h1234_5678);
        bus.req = 4'b0100;
        k = 0;
        while (!bus.spi_start && k < 20) begin
            @(negedge clk);
            bus.req = bus.req & ~bus.gnt;
            k++;
        end
        check("midwait_start_seen", bus.spi_start, 1);
        repeat (30) @(negedge clk);
        prev = rsp_seen;
        do_reset("rst_midwait");
        repeat (4) @(negedge clk);
        check("midwait_no_rsp", rsp_seen, prev);
        // After reset ptr must be 0: req[0] is served before req[3].
        done_delay = 5;
        exp_g(0, 5'b10010, 32'ha800_0545); exp_r(0, 1'b0, 32'ha800_0787, 6);
        exp_g(3, 5'b10000, 32'hffff_fe00); exp_r(3, 1'b0, 32'h0000_0042, 6);
        bus.req = 4'b1001;
        serve(2, 1'b1, 200);

        // Back-pressure from spi_ready and spi_busy.
        bus.spi_ready = 1'b0;
        bus.req = 4'b0010;
        prev = gnt_seen;
        repeat (10) @(negedge clk);
        check("bp_ready_low_no_gnt", gnt_seen, prev);
        bus.spi_ready = 1'b1;
        bus.spi_busy  = 1'b1;
        repeat (5) @(negedge clk);
        check("bp_busy_high_no_gnt", gnt_seen, prev);
        exp_g(1, 5'b10001, 32'h0000_1000);
        exp_r(1, 1'b0, 32'h0000_1242, 6);
        bus.spi_busy = 1'b0;
        @(negedge clk);
        check("bp_gnt_next_cycle", bus.gnt, 4'b0010);
        bus.req = '0;
        serve(1, 1'b1, 200);

        repeat (5) @(negedge clk);
        check("exp_gnt_drained", exp_gnt.size(), 0);
        check("exp_rsp_drained", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
